// File: rtl/input_debouncer.sv
// Input debouncer: two-flop synchroniser followed by a bounce filter that
// accepts a new level only after StableCycles consecutive agreeing samples.
// Emits one-cycle rise/fall strobes on the edge the debounced level changes.
module input_debouncer #(
    parameter int unsigned StableCycles = 4,
    parameter int unsigned CntWidth     = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    input  logic en_i,
    output logic dout_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CntWidth-1:0] CntLast = CntWidth'(StableCycles - 1);

    typedef enum logic [1:0] {
        StIdleLo,
        StWaitHi,
        StIdleHi,
        StWaitLo
    } state_e;

    logic                s1_q, s2_q;
    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic                dout_q, dout_d;
    logic                rise_q, rise_d;
    logic                fall_q, fall_d;

    // Synchroniser chain; runs regardless of enable.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= din_i;
            s2_q <= s1_q;
        end
    end

    // Filter state, counter and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdleLo;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Next-state logic: a disagreeing sample always wins over acceptance,
    // and a low enable always wins over everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;

        if (!en_i) begin
            state_d = dout_q ? StIdleHi : StIdleLo;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdleLo: begin
                    if (s2_q) begin
                        state_d = StWaitHi;
                        cnt_d   = CntWidth'(1);
                    end
                end
                StWaitHi: begin
                    if (!s2_q) begin
                        state_d = StIdleLo;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StIdleHi;
                        cnt_d   = '0;
                        dout_d  = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
                StIdleHi: begin
                    if (!s2_q) begin
                        state_d = StWaitLo;
                        cnt_d   = CntWidth'(1);
                    end
                end
                StWaitLo: begin
                    if (s2_q) begin
                        state_d = StIdleHi;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StIdleLo;
                        cnt_d   = '0;
                        dout_d  = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
                default: begin
                    state_d = StIdleLo;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer (80 ns clock, four-sample filter).
module tb_input_debouncer;

    logic clk = 1'b0;
    logic rst;
    logic din;
    logic en;
    logic dout;
    logic rise;
    logic fall;

    int vectors = 0;
    int miscompares = 0;

    input_debouncer #(
        .StableCycles(4),
        .CntWidth    (16)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .din_i (din),
        .en_i  (en),
        .dout_o(dout),
        .rise_o(rise),
        .fall_o(fall)
    );

    always #40 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic d, input logic r, input logic f);
        check({tag, ".dout"}, dout, d);
        check({tag, ".rise"}, rise, r);
        check({tag, ".fall"}, fall, f);
    endtask

    // Advance one rising edge and sample 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n edges; at index ev (or never if ev < 0) dout changes from d0 to d1
    // with a rise or fall pulse on exactly that edge.
    task automatic watch(input string tag, input int n, input int ev,
                         input logic r_ev, input logic f_ev,
                         input logic d0, input logic d1);
        for (int k = 0; k < n; k++) begin
            step();
            check_all($sformatf("%s[%0d]", tag, k),
                      (ev >= 0 && k >= ev) ? d1 : d0,
                      (k == ev) ? r_ev : 1'b0,
                      (k == ev) ? f_ev : 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        din = 1'b0;
        en  = 1'b1;
        #1;
        check_all("por", 1'b0, 1'b0, 1'b0);
        step();
        step();
        #20 rst = 1'b0;
        check_all("post_release", 1'b0, 1'b0, 1'b0);

        // Clean press and release: accepted on edge 5 after the change.
        step();
        din = 1'b1;
        watch("press", 8, 5, 1'b1, 1'b0, 1'b0, 1'b1);
        din = 1'b0;
        watch("release", 8, 5, 1'b0, 1'b1, 1'b1, 1'b0);

        // Bounce: three 3-cycle highs separated by 2-cycle lows, then hold high.
        for (int b = 0; b < 3; b++) begin
            din = 1'b1;
            watch($sformatf("bounce_hi%0d", b), 3, -1, 1'b0, 1'b0, 1'b0, 1'b0);
            din = 1'b0;
            watch($sformatf("bounce_lo%0d", b), 2, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        din = 1'b1;
        watch("bounce_hold", 8, 5, 1'b1, 1'b0, 1'b0, 1'b1);

        // Back to low before the boundary cases.
        din = 1'b0;
        watch("fall2", 8, 5, 1'b0, 1'b1, 1'b1, 1'b0);

        // Three high samples: reversal on the acceptance edge, no pulse.
        din = 1'b1;
        watch("b3_hi", 3, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        din = 1'b0;
        watch("b3_lo", 5, -1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Four high samples: accepted on edge 5, then the low is filtered too.
        din = 1'b1;
        watch("b4_hi", 4, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        din = 1'b0;
        watch("b4_rise", 4, 1, 1'b1, 1'b0, 1'b0, 1'b1);
        watch("b4_fall", 4, 1, 1'b0, 1'b1, 1'b1, 1'b0);

        // Enable gating at cnt==3: counting restarts, rise 4 edges after re-enable.
        din = 1'b1;
        watch("en_pre", 5, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        watch("en_off", 2, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b1;
        watch("en_on", 6, 3, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset while waiting to fall, with din returning high.
        din = 1'b0;
        watch("wait_lo", 4, -1, 1'b0, 1'b0, 1'b1, 1'b1);
        din = 1'b1;
        #20 rst = 1'b1;
        #1;
        check_all("rst_async", 1'b0, 1'b0, 1'b0);
        step();
        check_all("rst_held", 1'b0, 1'b0, 1'b0);
        #20 rst = 1'b0;
        watch("post_rst", 8, 5, 1'b1, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
